// File: rtl/mem_pkg.sv
// Shared widths and FSM state encoding for the memory initiator.
package mem_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int IMM_W  = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CAPT  = 2'd2,
      RESP  = 2'd3
   } state_e;

endpackage

// File: rtl/mem_initiator_agu.sv
// Address generation: base + sign-extended immediate, word index and range flag.
module mem_initiator_agu #(
   parameter int ADDR_W = mem_pkg::ADDR_W,
   parameter int DATA_W = mem_pkg::DATA_W,
   parameter int IMM_W  = mem_pkg::IMM_W
) (
   input  logic [DATA_W-1:0] base,
   input  logic [IMM_W-1:0]  imm,
   output logic [ADDR_W-1:0] idx,
   output logic              out_of_range
);
   import mem_pkg::*;

   logic [DATA_W-1:0] ea;

   always_comb begin
      ea           = base + {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      idx          = ea[ADDR_W-1:0];
      out_of_range = |ea[DATA_W-1:ADDR_W];
   end

endmodule

// File: rtl/mem_initiator.sv
// Command-driven load/store initiator for the 32x32 memory block.
// Define MEM_INITIATOR_RANGE_CHK_EN to flag out-of-range addresses via rsp_err.
module mem_initiator #(
   parameter int ADDR_W = mem_pkg::ADDR_W,
   parameter int DATA_W = mem_pkg::DATA_W,
   parameter int IMM_W  = mem_pkg::IMM_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [DATA_W-1:0] cmd_base,
   input  logic [IMM_W-1:0]  cmd_imm,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data
);
   import mem_pkg::*;

`ifdef MEM_INITIATOR_RANGE_CHK_EN
   localparam bit RANGE_CHK_EN = 1'b1;
`else
   localparam bit RANGE_CHK_EN = 1'b0;
`endif

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] agu_idx;
   logic              agu_oor;

   mem_initiator_agu #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .IMM_W (IMM_W)
   ) u_agu (
      .base        (cmd_base),
      .imm         (cmd_imm),
      .idx         (agu_idx),
      .out_of_range(agu_oor)
   );

   // NOTE: every *_d gets its hold value first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               we_d    = cmd_we;
               addr_d  = agu_idx;
               wdata_d = cmd_wdata;
               rdata_d = '0;
               err_d   = 1'b0;
               if (RANGE_CHK_EN && agu_oor) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE:   state_d = we_q ? RESP : CAPT;
         CAPT: begin
            rdata_d = rd_data;
            state_d = RESP;
         end
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments only in sequential logic, so every flop sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Strobes are gated by rst so a reset during ISSUE suppresses the access that same cycle.
   always_comb begin
      cmd_ready = (state_q == IDLE);
      rsp_valid = (state_q == RESP);
      wr_en     = (state_q == ISSUE) && we_q && !rst;
      rd_en     = (state_q == ISSUE) && !we_q && !rst;
      wr_addr   = addr_q;
      rd_addr   = addr_q;
      wr_data   = wdata_q;
      rsp_rdata = rdata_q;
      rsp_err   = err_q;
   end

endmodule
